// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx - I2S master transmitter (playback path) with Avalon-MM slave front end
//
// The host writes 16-bit stereo samples into a small pair FIFO. The block
// divides clk down to the serial bit clock, frames 64 SCK periods per stereo
// frame (32 per channel) and shifts each sample out MSB-first as a 24-bit word
// ({sample, 8'h00}), delayed one SCK after the WS edge as in standard I2S.
// SD and WS change only when SCK falls, so the DAC samples them on SCK rising.
//
// Ports
//   clk         system clock, everything runs on its rising edge
//   reset       synchronous, active-low reset
//   chipselect  Avalon-MM select
//   read        Avalon-MM read strobe
//   write       Avalon-MM write strobe
//   address     register select (0 left stage, 1 push right, 2 status, 3 ctrl)
//   writedata   write data
//   readdata    registered read data, one clk after chipselect&&read
//   irq         level interrupt, FIFO at or below the low-water mark while enabled
//   SCK         serial bit clock to the DAC
//   WS          word select, 0 = left, 1 = right
//   SD          serial data to the DAC
// -----------------------------------------------------------------------------
module i2s_tx #(
  parameter int DIV        = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LOW_WATER  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        SCK,
  output logic        WS,
  output logic        SD
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LOW_LVL   = LW'(LOW_WATER);

  // Bus-side registers
  logic          r_en;
  logic [15:0]   r_left_stage;
  logic          r_ovf;
  logic          r_unf;
  logic [15:0]   r_readdata;
  logic          r_irq;

  // Serial side registers
  logic [DW-1:0] r_div_cnt;
  logic          r_sck;
  logic          r_ws;
  logic          r_sd;
  logic [5:0]    r_bit_cnt;
  logic [23:0]   r_tx_l;
  logic [23:0]   r_tx_r;

  // FIFO storage: each entry is {left, right}
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic          w_bus_wr;
  logic          w_bus_rd;
  logic          w_push;
  logic          w_push_ok;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_tick;
  logic          w_fall;
  logic          w_wrap;
  logic          w_underrun;
  logic          w_rd_status;
  logic [5:0]    w_bit_next;
  logic [31:0]   w_head;
  logic [15:0]   w_status;
  logic          w_sd_next;
  logic [4:0]    w_idx_l;
  logic [4:0]    w_idx_r;

  assign w_bus_wr    = chipselect && write;
  assign w_bus_rd    = chipselect && read;
  assign w_push      = w_bus_wr && (address == 3'd1);
  assign w_rd_status = w_bus_rd && (address == 3'd2);
  assign w_empty     = (r_level == {LW{1'b0}});
  assign w_full      = (r_level == DEPTH_LVL);

  // fall is the clk in which SCK goes 1->0; all framing happens there
  assign w_tick      = r_en && (r_div_cnt == DIV_LAST);
  assign w_fall      = w_tick && r_sck;
  assign w_bit_next  = r_bit_cnt + 6'd1;
  assign w_wrap      = w_fall && (w_bit_next == 6'd0);
  assign w_pop       = w_wrap && !w_empty;
  assign w_underrun  = w_wrap && w_empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same clk
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_head      = r_mem[r_rptr];

  assign w_status    = {9'd0, r_ovf, r_unf, w_empty, w_full, 3'(r_level)};

  assign readdata    = r_readdata;
  assign irq         = r_irq;
  assign SCK         = r_sck;
  assign WS          = r_ws;
  assign SD          = r_sd;

  // Select the serial bit for the count being entered: data is delayed one
  // SCK after the WS edge, so bit n of the channel word goes out at count n+1.
  always_comb begin
    w_sd_next = 1'b0;
    w_idx_l   = 5'(6'd24 - w_bit_next);
    w_idx_r   = 5'(6'd56 - w_bit_next);
    if ((w_bit_next >= 6'd1) && (w_bit_next <= 6'd24)) begin
      w_sd_next = r_tx_l[w_idx_l];
    end else if ((w_bit_next >= 6'd33) && (w_bit_next <= 6'd56)) begin
      w_sd_next = r_tx_r[w_idx_r];
    end else begin
      w_sd_next = 1'b0;
    end
  end

  // Register interface: staging, control, sticky flags and read data
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_en         <= 1'b0;
      r_left_stage <= 16'h0000;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_readdata   <= 16'h0000;
    end else begin
      if (w_bus_wr && (address == 3'd0)) begin
        r_left_stage <= writedata;
      end
      if (w_bus_wr && (address == 3'd3)) begin
        r_en <= writedata[0];
      end
      // A flag event in the same clk as the status read wins over the clear
      if (w_push && !w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (w_rd_status) begin
        r_ovf <= 1'b0;
      end
      if (w_underrun) begin
        r_unf <= 1'b1;
      end else if (w_rd_status) begin
        r_unf <= 1'b0;
      end
      if (w_bus_rd) begin
        case (address)
          3'd2:    r_readdata <= w_status;
          3'd3:    r_readdata <= {15'd0, r_en};
          default: r_readdata <= 16'h0000;
        endcase
      end
    end
  end

  // FIFO entry storage; contents are don't-care until pointed at by the read pointer
  always_ff @(posedge clk) begin
    if (reset && w_push_ok) begin
      r_mem[r_wptr] <= {r_left_stage, writedata};
    end
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_level <= {LW{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Bit clock divider, frame counter, word select, serial data and frame load
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt <= {DW{1'b0}};
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
      r_sd      <= 1'b0;
      r_bit_cnt <= 6'd0;
      r_tx_l    <= 24'h000000;
      r_tx_r    <= 24'h000000;
    end else if (!r_en) begin
      // Parked so that re-enabling starts a clean frame at count 0
      r_div_cnt <= {DW{1'b0}};
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
      r_sd      <= 1'b0;
      r_bit_cnt <= 6'd0;
      r_tx_l    <= 24'h000000;
      r_tx_r    <= 24'h000000;
    end else begin
      if (w_tick) begin
        r_div_cnt <= {DW{1'b0}};
        r_sck     <= ~r_sck;
      end else begin
        r_div_cnt <= r_div_cnt + DW'(1);
      end
      if (w_fall) begin
        r_bit_cnt <= w_bit_next;
        r_ws      <= w_bit_next[5];
        r_sd      <= w_sd_next;
      end
      if (w_pop) begin
        r_tx_l <= {w_head[31:16], 8'h00};
        r_tx_r <= {w_head[15:0], 8'h00};
      end else if (w_underrun) begin
        r_tx_l <= 24'h000000;
        r_tx_r <= 24'h000000;
      end
    end
  end

  // Low-water interrupt, one clk behind the level it reflects
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_en && (r_level <= LOW_LVL);
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx - directed, self-checking bench for i2s_tx (DIV=8, depth 4, LW 1)
// A table of register accesses covers the bus side; hand-written sequences
// capture whole serial frames and exercise the frame-boundary corner cases.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  logic        SCK;
  logic        WS;
  logic        SD;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit          is_rd;
    logic [2:0]  addr;
    logic [15:0] data;   // write data, or expected read data
  } vec_t;

  vec_t tbl [21];

  always #5 clk = ~clk;

  i2s_tx #(.DIV(8), .FIFO_DEPTH(4), .LOW_WATER(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .SCK        (SCK),
    .WS         (WS),
    .SD         (SD)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_rise(output bit ok, output int cyc);
    logic p;
    p = SCK; ok = 1'b0; cyc = 0;
    while (!ok && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (SCK && !p) ok = 1'b1;
      p = SCK;
    end
  endtask

  task automatic wait_ws_fall(output bit ok);
    logic p;
    int c;
    p = WS; ok = 1'b0; c = 0;
    while (!ok && c < 2200) begin
      @(negedge clk);
      c++;
      if (!WS && p) ok = 1'b1;
      p = WS;
    end
  endtask

  // Capture one frame starting at the WS falling edge, sampling on SCK rise
  task automatic capture_frame(output bit ok, output logic [23:0] l,
                               output logic [23:0] r, output int errs);
    int cyc;
    int total;
    logic [5:0] kb;
    l = 24'h0; r = 24'h0; errs = 0; total = 0;
    wait_ws_fall(ok);
    for (int k = 0; k < 64; k++) begin
      if (ok) begin
        wait_rise(ok, cyc);
        total += cyc;
        kb = 6'(k);
        if (cyc != ((k == 0) ? 8 : 16)) errs++;
        if (WS !== kb[5]) errs++;
        if (k >= 1 && k <= 24) l = {l[22:0], SD};
        else if (k >= 33 && k <= 56) r = {r[22:0], SD};
        else if (SD !== 1'b0) errs++;
      end
    end
    if (total != 1016) errs++;
  endtask

  task automatic check_frame(input string name, input logic [15:0] el, input logic [15:0] er);
    bit ok;
    logic [23:0] l;
    logic [23:0] r;
    int errs;
    capture_frame(ok, l, r, errs);
    check({name, "_done"}, 32'(ok), 32'd1);
    check({name, "_left"}, 32'(l), {8'h00, el, 8'h00});
    check({name, "_right"}, 32'(r), {8'h00, er, 8'h00});
    check({name, "_timing"}, 32'(errs), 32'd0);
  endtask

  initial begin
    logic [15:0] rd;
    bit ok;
    bit ok_all;
    int cyc;
    int c;

    tbl[0]  = '{1'b1, 3'd2, 16'h0010};
    tbl[1]  = '{1'b1, 3'd3, 16'h0000};
    tbl[2]  = '{1'b1, 3'd6, 16'h0000};
    tbl[3]  = '{1'b0, 3'd0, 16'hA5F0};
    tbl[4]  = '{1'b0, 3'd1, 16'h0F0F};
    tbl[5]  = '{1'b1, 3'd2, 16'h0001};
    tbl[6]  = '{1'b0, 3'd0, 16'h8001};
    tbl[7]  = '{1'b0, 3'd1, 16'h7FFF};
    tbl[8]  = '{1'b1, 3'd2, 16'h0002};
    tbl[9]  = '{1'b0, 3'd0, 16'hFFFF};
    tbl[10] = '{1'b0, 3'd1, 16'h0001};
    tbl[11] = '{1'b0, 3'd0, 16'h1234};
    tbl[12] = '{1'b0, 3'd1, 16'hABCD};
    tbl[13] = '{1'b1, 3'd2, 16'h000C};
    tbl[14] = '{1'b0, 3'd0, 16'hDEAD};
    tbl[15] = '{1'b0, 3'd1, 16'hBEEF};
    tbl[16] = '{1'b1, 3'd2, 16'h004C};
    tbl[17] = '{1'b1, 3'd2, 16'h000C};
    tbl[18] = '{1'b0, 3'd5, 16'hFFFF};
    tbl[19] = '{1'b1, 3'd2, 16'h000C};
    tbl[20] = '{1'b1, 3'd0, 16'h0000};

    reset = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = 3'd0; writedata = 16'h0000;

    // Reset held for 3 clk
    repeat (3) @(negedge clk);
    check("rst_sck", 32'(SCK), 32'd0);
    check("rst_ws", 32'(WS), 32'd0);
    check("rst_sd", 32'(SD), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readdata", 32'(readdata), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Register table with en=0: fill, overflow, sticky clear, ignored address
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].is_rd) begin
        bus_read(tbl[i].addr, rd);
        check($sformatf("vec%0d_rd_a%0d", i, tbl[i].addr), 32'(rd), 32'(tbl[i].data));
      end else begin
        bus_write(tbl[i].addr, tbl[i].data);
      end
    end
    check("idle_sck", 32'(SCK), 32'd0);
    check("idle_irq", 32'(irq), 32'd0);

    bus_write(3'd3, 16'h0001);
    bus_read(3'd3, rd);
    check("ctrl_en", 32'(rd), 32'h0001);
    check("irq_full", 32'(irq), 32'd0);

    // Pairs 1..3 in order; irq follows the level
    check_frame("f1", 16'hA5F0, 16'h0F0F);
    check_frame("f2", 16'h8001, 16'h7FFF);
    check("irq_lvl2", 32'(irq), 32'd0);
    check_frame("f3", 16'hFFFF, 16'h0001);
    check("irq_lvl1", 32'(irq), 32'd1);

    // Push one pair before the next boundary: irq drops within 2 clk
    bus_write(3'd0, 16'h5A5A);
    bus_write(3'd1, 16'hC3C3);
    @(negedge clk);
    check("irq_after_push", 32'(irq), 32'd0);
    bus_read(3'd2, rd);
    check("status_lvl2", 32'(rd), 32'h0002);

    // Pair 4 then the new pair; the dropped pair never appears
    check_frame("f4", 16'h1234, 16'hABCD);
    check_frame("f5", 16'h5A5A, 16'hC3C3);
    check_frame("f6_unf", 16'h0000, 16'h0000);
    check_frame("f7_unf", 16'h0000, 16'h0000);
    check("irq_empty", 32'(irq), 32'd1);
    bus_read(3'd2, rd);
    check("status_unf", 32'(rd), 32'h0030);
    bus_read(3'd2, rd);
    check("status_unf_clr", 32'(rd), 32'h0010);

    // Fill to 4 right after a boundary, then push exactly on the next boundary
    wait_ws_fall(ok);
    check("boundary_seen", 32'(ok), 32'd1);
    bus_write(3'd0, 16'hA5F0); bus_write(3'd1, 16'h0F0F);
    bus_write(3'd0, 16'h8001); bus_write(3'd1, 16'h7FFF);
    bus_write(3'd0, 16'hFFFF); bus_write(3'd1, 16'h0001);
    bus_write(3'd0, 16'h1234); bus_write(3'd1, 16'hABCD);
    bus_read(3'd2, rd);
    check("status_full_unf", 32'(rd), 32'h002C);
    bus_write(3'd0, 16'hDEAD);
    c = 0;
    while (WS !== 1'b1 && c < 1200) begin
      @(negedge clk);
      c++;
    end
    check("ws_high_seen", 32'(WS), 32'd1);
    ok_all = 1'b1;
    for (int k = 0; k < 32; k++) begin
      wait_rise(ok, cyc);
      ok_all = ok_all && ok;
    end
    check("rise63_seen", 32'(ok_all), 32'd1);
    // The fall ending bit 63 is 8 clk after its rise; push lands in that clk
    repeat (6) @(negedge clk);
    bus_write(3'd1, 16'hBEEF);
    bus_read(3'd2, rd);
    check("status_pushpop", 32'(rd), 32'h000C);
    wait_rise(ok, cyc);
    wait_rise(ok, cyc);
    check("mid_rise_ok", 32'(ok), 32'd1);
    check("mid_sck", 32'(SCK), 32'd1);
    check("mid_sd_msb", 32'(SD), 32'd1);

    // Reset mid-frame: everything clears on the next clk
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_sck", 32'(SCK), 32'd0);
    check("mrst_ws", 32'(WS), 32'd0);
    check("mrst_sd", 32'(SD), 32'd0);
    check("mrst_irq", 32'(irq), 32'd0);
    check("mrst_readdata", 32'(readdata), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus_read(3'd2, rd);
    check("mrst_status", 32'(rd), 32'h0010);
    bus_read(3'd3, rd);
    check("mrst_ctrl", 32'(rd), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
